register_shft_seq: RTL and testbench

//  Parametrised sequential universal shift register; successor to register_shft.

---
 rtl/register_shft_seq.sv | 128 ++++++++++++
 tb/tb_register_shft_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_shft_seq.sv
// Sequential universal shift register: load/clear/hold plus shift and rotate
// ops executed one bit per cycle under a start/busy/done handshake.
module register_shft_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic             en,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in_l,
    input  logic             s_in_r,
    output logic [WIDTH-1:0] out,
    output logic             s_out_l,
    output logic             s_out_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [2:0]       op_q, op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;

    function automatic logic [WIDTH-1:0] step_f(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        case (o)
            OP_SHL:  r = {v[WIDTH-2:0], sr};
            OP_SHR:  r = {sl, v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        op_d    = op_q;
        if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
        if (accept) begin
            op_d    = op;
            state_d = S_DONE;
            rem_d   = '0;
            case (op)
                OP_HOLD:  out_d = out_q;
                OP_LOAD:  out_d = p_in;
                OP_CLEAR: out_d = '0;
                default: begin
                    if (amt != '0) begin
                        out_d = step_f(op, out_q, s_in_l, s_in_r);
                    end
                    // first step happens on the accept edge itself
                    if (amt > AMT_W'(1)) begin
                        rem_d   = amt - AMT_W'(1);
                        state_d = S_RUN;
                    end
                end
            endcase
        end else if (state_q == S_RUN && en) begin
            out_d = step_f(op_q, out_q, s_in_l, s_in_r);
            rem_d = rem_q - AMT_W'(1);
            if (rem_q == AMT_W'(1)) begin
                state_d = S_DONE;
            end
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out     = out_q;
    assign s_out_l = out_q[WIDTH-1];
    assign s_out_r = out_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_register_shft_seq.sv
// Scoreboard bench for register_shft_seq: stimulus queues expected result
// and completion cycle, a monitor checks every done pulse against it.
module tb_register_shft_seq;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         reset, start, en, s_in_l, s_in_r;
    logic [2:0]   op;
    logic [A-1:0] amt;
    logic [W-1:0] p_in, out;
    logic         s_out_l, s_out_r, busy, done;

    typedef struct {
        logic [W-1:0] v;
        int           c;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    register_shft_seq #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt),
        .en(en), .p_in(p_in), .s_in_l(s_in_l), .s_in_r(s_in_r),
        .out(out), .s_out_l(s_out_l), .s_out_r(s_out_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt = busy_cnt + 1;
        if (!reset && done) begin
            exp_t e;
            checks = checks + 1;
            if (q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL done_unexpected cyc=%0d out=%h", cyc, out);
            end else begin
                e = q.pop_front();
                if (out !== e.v || cyc != e.c) begin
                    failures = failures + 1;
                    $display("FAIL done_result got out=%h cyc=%0d want out=%h cyc=%0d",
                             out, cyc, e.v, e.c);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // lat: cycles from accept edge to the cycle done is visible, inclusive
    task automatic issue(input logic [2:0] o, input logic [A-1:0] k,
                         input logic [W-1:0] d, input int lat,
                         input logic [W-1:0] ev, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        amt   = k;
        p_in  = d;
        if (expect_done) begin
            e.v = ev;
            e.c = cyc + lat;
            q.push_back(e);
        end
    endtask

    task automatic quiet();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain_timeout pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        en     = 1'b1;
        op     = 3'b000;
        amt    = '0;
        p_in   = '0;
        s_in_l = 1'b0;
        s_in_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out", out, 8'h00);
        chk("reset_flags", {4'b0, s_out_l, s_out_r, busy, done}, 8'h00);
        reset = 1'b0;

        busy_cnt = 0;
        issue(3'b001, 4'd0, 8'hA5, 1, 8'hA5, 1'b1);
        quiet();
        drain();
        chk("load_busy", W'(busy_cnt), 8'd0);
        chk("load_serial", {6'b0, s_out_l, s_out_r}, 8'h03);

        busy_cnt = 0;
        s_in_r = 1'b1;
        issue(3'b010, 4'd3, 8'h00, 3, 8'h2F, 1'b1);
        quiet();
        drain();
        s_in_r = 1'b0;
        chk("shl3_busy", W'(busy_cnt), 8'd2);
        chk("shl3_serial", {6'b0, s_out_l, s_out_r}, 8'h01);

        issue(3'b001, 4'd0, 8'h90, 1, 8'h90, 1'b1);
        quiet();
        issue(3'b110, 4'd2, 8'h00, 2, 8'hE4, 1'b1);
        quiet();
        drain();

        issue(3'b001, 4'd0, 8'h81, 1, 8'h81, 1'b1);
        quiet();
        issue(3'b101, 4'd9, 8'h00, 9, 8'hC0, 1'b1);
        quiet();
        drain();

        s_in_l = 1'b1;
        issue(3'b001, 4'd0, 8'h02, 1, 8'h02, 1'b1);
        quiet();
        issue(3'b011, 4'd1, 8'h00, 1, 8'h81, 1'b1);
        quiet();
        drain();
        s_in_l = 1'b0;

        // back-to-back: second start accepted while done is high
        issue(3'b100, 4'd0, 8'h00, 1, 8'h81, 1'b1);
        issue(3'b111, 4'd0, 8'h00, 1, 8'h00, 1'b1);
        issue(3'b000, 4'd0, 8'hFF, 1, 8'h00, 1'b1);
        quiet();
        drain();

        issue(3'b001, 4'd0, 8'h01, 1, 8'h01, 1'b1);
        quiet();
        busy_cnt = 0;
        issue(3'b010, 4'd4, 8'h00, 6, 8'h10, 1'b1);
        quiet();
        @(negedge clk);
        en    = 1'b0;
        start = 1'b1;
        op    = 3'b001;
        p_in  = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        en    = 1'b1;
        start = 1'b0;
        drain();
        chk("stall_busy", W'(busy_cnt), 8'd5);

        issue(3'b001, 4'd0, 8'h5A, 1, 8'h5A, 1'b1);
        quiet();
        issue(3'b100, 4'd7, 8'h00, 7, 8'h00, 1'b0);
        quiet();
        @(negedge clk);
        chk("rol_midrun_busy", {7'b0, busy}, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_run_out", out, 8'h00);
        chk("rst_run_flags", {6'b0, busy, done}, 8'h00);
        @(negedge clk);
        chk("rst_run_nodone", {7'b0, done}, 8'h00);
        issue(3'b001, 4'd0, 8'h3C, 1, 8'h3C, 1'b1);
        quiet();
        drain();
        chk("final_out", out, 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
